// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand feeder and result capture for a 3x3 systolic array
module systolic_feeder #(
  parameter int DW           = 8,
  parameter int CW           = 16,
  parameter int DRAIN_CYCLES = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [9*DW-1:0] a_mat,
  input  logic [9*DW-1:0] b_mat,
  output logic            arr_rst,
  output logic [3*DW-1:0] arr_a,
  output logic [3*DW-1:0] arr_b,
  input  logic [9*CW-1:0] arr_c,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [9*CW-1:0] res_c,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_DRAIN, S_HOLD} state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [9*DW-1:0]  a_q, b_q;
  logic             accept;

  logic             in_ready_d, arr_rst_d, res_valid_d, busy_d;
  logic [3*DW-1:0]  arr_a_d, arr_b_d;

  assign accept = in_valid && in_ready;

  // Column k of A: one element per array row.
  function automatic logic [3*DW-1:0] a_col(input logic [9*DW-1:0] m, input logic [1:0] k);
    logic [3*DW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*DW +: DW] = m[(3*i + int'(k))*DW +: DW];
    return r;
  endfunction

  function automatic logic [3*DW-1:0] b_row(input logic [9*DW-1:0] m, input logic [1:0] k);
    logic [3*DW-1:0] r;
    r = '0;
    for (int j = 0; j < 3; j++) r[j*DW +: DW] = m[(3*int'(k) + j)*DW +: DW];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_CLR;
          cnt_next   = '0;
        end
      end
      S_CLR: begin
        if (cnt == CNT_W'(1)) begin
          state_next = S_FEED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_FEED: begin
        if (cnt == CNT_W'(2)) begin
          state_next = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (res_valid && res_ready) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    in_ready_d  = (state_next == S_IDLE);
    busy_d      = (state_next != S_IDLE);
    arr_rst_d   = (state_next != S_CLR);
    res_valid_d = (state_next == S_HOLD);
    arr_a_d     = '0;
    arr_b_d     = '0;
    if (state_next == S_FEED) begin
      arr_a_d = a_col(a_q, cnt_next[1:0]);
      arr_b_d = b_row(b_q, cnt_next[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      arr_rst   <= 1'b0;
      res_valid <= 1'b0;
      arr_a     <= '0;
      arr_b     <= '0;
      res_c     <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      arr_rst   <= arr_rst_d;
      res_valid <= res_valid_d;
      arr_a     <= arr_a_d;
      arr_b     <= arr_b_d;
      if (accept) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      if (state == S_DRAIN && cnt == DRAIN_LAST) res_c <= arr_c;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed scoreboard bench for systolic_feeder with a behavioural array
module tb_systolic_feeder;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int DC = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [9*DW-1:0] a_mat, b_mat;
  logic            arr_rst;
  logic [3*DW-1:0] arr_a, arr_b;
  logic [9*CW-1:0] arr_c;
  logic            res_valid, res_ready;
  logic [9*CW-1:0] res_c;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  logic [143:0] exp_q[$];

  systolic_feeder #(.DW(DW), .CW(CW), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_rst(arr_rst), .arr_a(arr_a), .arr_b(arr_b),
    .arr_c(arr_c), .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Outer-product accumulator array: sync active-low clear, C += a_i * b_j each cycle.
  logic [CW-1:0] acc[9];
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (!arr_rst) acc[3*i+j] <= '0;
        else acc[3*i+j] <= acc[3*i+j] + 16'(arr_a[i*DW +: DW]) * 16'(arr_b[j*DW +: DW]);
  end
  always_comb begin
    arr_c = '0;
    for (int n = 0; n < 9; n++) arr_c[n*CW +: CW] = acc[n];
  end

  function automatic logic [143:0] matmul(input logic [71:0] a, input logic [71:0] b);
    logic [143:0] r;
    logic [15:0]  s;
    r = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = '0;
        for (int k = 0; k < 3; k++) s = s + 16'(a[(3*i+k)*8 +: 8]) * 16'(b[(3*k+j)*8 +: 8]);
        r[(3*i+j)*16 +: 16] = s;
      end
    return r;
  endfunction

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic run_op(input logic [71:0] a, input logic [71:0] b, input int hold,
                        input bit pulse, output logic [143:0] got);
    int n;
    int cyc;
    logic [143:0] first;
    logic [143:0] exp;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {143'd0, in_ready}, 144'd1);
    a_mat = a;
    b_mat = b;
    in_valid = 1'b1;
    exp_q.push_back(matmul(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    check("busy_after_accept", {143'd0, busy}, 144'd1);
    check("in_ready_after_accept", {143'd0, in_ready}, 144'd0);
    while (!res_valid && cyc < 60) begin
      if (pulse && (cyc == 4 || cyc == 8)) begin
        in_valid = 1'b1;
        a_mat = ~a;
        b_mat = ~b;
        check("in_ready_low_busy", {143'd0, in_ready}, 144'd0);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 144'(cyc), 144'd13);
    first = res_c;
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", {143'd0, res_valid}, 144'd1);
      check("hold_stable", res_c, first);
      @(negedge clk);
    end
    res_ready = 1'b1;
    if (exp_q.size() == 0) begin
      exp = '1;
      check("scoreboard_empty", 144'(exp_q.size()), 144'd1);
    end else begin
      exp = exp_q.pop_front();
    end
    check("res_c", res_c, exp);
    got = res_c;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_drop", {143'd0, res_valid}, 144'd0);
    check("in_ready_back", {143'd0, in_ready}, 144'd1);
  endtask

  logic [71:0]  m_id, m_seq, m_ff, m_two, m_one;
  logic [143:0] got;

  initial begin
    for (int i = 0; i < 9; i++) begin
      m_id[i*8 +: 8]  = (i % 4 == 0) ? 8'd1 : 8'd0;
      m_seq[i*8 +: 8] = 8'(i + 1);
      m_ff[i*8 +: 8]  = 8'hff;
      m_two[i*8 +: 8] = 8'd2;
      m_one[i*8 +: 8] = 8'd1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    a_mat = '0;
    b_mat = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {143'd0, in_ready}, 144'd1);
    check("rst_busy", {143'd0, busy}, 144'd0);
    check("rst_arr_rst", {143'd0, arr_rst}, 144'd0);
    check("rst_res_valid", {143'd0, res_valid}, 144'd0);
    check("rst_res_c", res_c, 144'd0);
    check("rst_arr_ab", {96'd0, arr_a, arr_b}, 144'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_arr_rst", {143'd0, arr_rst}, 144'd1);

    run_op(m_id, m_seq, 0, 1'b0, got);
    check("ident_c22", {128'd0, got[8*16 +: 16]}, 144'd9);
    check("ident_c00", {128'd0, got[0 +: 16]}, 144'd1);

    run_op(m_ff, m_ff, 0, 1'b0, got);
    check("wrap_c11", {128'd0, got[4*16 +: 16]}, 144'd64003);

    run_op(m_id, m_seq, 5, 1'b0, got);

    run_op(m_id, m_two, 0, 1'b0, got);
    run_op(m_id, m_one, 0, 1'b0, got);
    check("b2b_c00", {128'd0, got[0 +: 16]}, 144'd1);
    check("b2b_c21", {128'd0, got[7*16 +: 16]}, 144'd1);

    run_op(m_seq, m_id, 0, 1'b1, got);
    repeat (15) @(negedge clk);
    check("pulse_no_second_result", {143'd0, res_valid}, 144'd0);
    check("pulse_idle", {143'd0, busy}, 144'd0);
    check("pulse_queue_empty", 144'(exp_q.size()), 144'd0);

    // Reset while FEED is on beat k=1.
    a_mat = m_id;
    b_mat = m_seq;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("feed_k1_arr_a", {120'd0, arr_a}, 144'h000100);
    check("feed_k1_arr_b", {120'd0, arr_b}, 144'h060504);
    rst = 1'b0;
    #1;
    check("async_busy", {143'd0, busy}, 144'd0);
    check("async_in_ready", {143'd0, in_ready}, 144'd1);
    check("async_arr_rst", {143'd0, arr_rst}, 144'd0);
    check("async_arr_ab", {96'd0, arr_a, arr_b}, 144'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(m_seq, m_seq, 0, 1'b0, got);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
